// File: rtl/mii_rx_pkg.sv
// Shared types, constants and helpers for the MII receive deframer.
package mii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  // Reflected CRC-32 update, one byte, LSB first.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Bit reversal: the reflected register holds the residue in LSB-first order.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Registered reflected CRC-32, 8 bits per cycle, with synchronous init and enable.
module eth_crc32_d8
  import mii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  // Next CRC: init has priority over a byte update.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_d8_next(crc_q, data);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes, writes the
// byte-enabled RX buffer and publishes done/length status after FCS/length checks.
// Optional destination address filter: define RX_ADDR_FILTER_EN.
module mii_rx_deframer
  import mii_rx_pkg::*;
#(
  parameter int unsigned BUF_AW  = 8,
  parameter int unsigned MAX_LEN = 1536,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic              clk_mii,
  input  logic              rstn,
  input  logic [3:0]        i_erxd,
  input  logic              i_erx_dv,
  input  logic              i_erx_er,
  input  logic              rx_ack,
`ifdef RX_ADDR_FILTER_EN
  input  logic [47:0]       mac_addr,
  input  logic              promisc,
`endif
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [63:0]       buf_wdata,
  output logic [7:0]        buf_be,
  output logic              rx_done,
  output logic [10:0]       rx_len,
  output logic              rx_busy,
  output logic [15:0]       rx_drop_cnt,
  output logic [15:0]       rx_err_cnt
);

  localparam int unsigned IDX_W = BUF_AW + 3;
  localparam int unsigned LEN_W = 11;

  state_e              state_q, state_d;
  logic [3:0]          nib_lo_q, nib_lo_d;
  logic                nib_ph_q, nib_ph_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                buf_we_q, buf_we_d;
  logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
  logic [63:0]         buf_wdata_q, buf_wdata_d;
  logic [7:0]          buf_be_q, buf_be_d;
  logic                rx_done_q, rx_done_d;
  logic [LEN_W-1:0]    rx_len_q, rx_len_d;
  logic                busy_q, busy_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic                crc_init_c, crc_en_c;
  logic [31:0]         crc_c;
  logic [7:0]          byte_c;
  logic                frame_ok_c;

  eth_crc32_d8 u_crc (
    .clk   (clk_mii),
    .rst_n (rstn),
    .init  (crc_init_c),
    .en    (crc_en_c),
    .data  (byte_c),
    .crc   (crc_c)
  );

`ifdef RX_ADDR_FILTER_EN
  logic       ucast_miss_q, ucast_miss_d;
  logic       bcast_miss_q, bcast_miss_d;
  logic [7:0] da_exp_c;
  logic       da_reject_c;

  // Expected DA byte for the current index; byte 0 is the MSB of mac_addr.
  always_comb begin
    da_exp_c = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (byte_idx_q == IDX_W'(k)) da_exp_c = mac_addr[8*(5-k) +: 8];
    end
    da_reject_c = (byte_idx_q == IDX_W'(6)) && !promisc && ucast_miss_q && bcast_miss_q;
  end

  // DA mismatch flags.
  always_ff @(posedge clk_mii or negedge rstn) begin
    if (!rstn) begin
      ucast_miss_q <= 1'b0;
      bcast_miss_q <= 1'b0;
    end else begin
      ucast_miss_q <= ucast_miss_d;
      bcast_miss_q <= bcast_miss_d;
    end
  end
`endif

  // Next-state, buffer write and status logic.
  always_comb begin
    state_d     = state_q;
    nib_lo_d    = nib_lo_q;
    nib_ph_d    = nib_ph_q;
    byte_idx_d  = byte_idx_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    buf_be_d    = buf_be_q;
    rx_done_d   = rx_done_q;
    rx_len_d    = rx_len_q;
    drop_cnt_d  = drop_cnt_q;
    err_cnt_d   = err_cnt_q;
    crc_init_c  = 1'b0;
    crc_en_c    = 1'b0;
    byte_c      = {i_erxd, nib_lo_q};
`ifdef RX_ADDR_FILTER_EN
    ucast_miss_d = ucast_miss_q;
    bcast_miss_d = bcast_miss_q;
`endif
    frame_ok_c = !nib_ph_q && !err_q && !ovf_q
                 && (byte_idx_q >= IDX_W'(MIN_LEN)) && (byte_idx_q <= IDX_W'(MAX_LEN))
                 && (bitrev32(crc_c) == CRC32_RESIDUE);

    if (rx_ack) rx_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_erx_dv) begin
          if (rx_done_q) begin
            state_d    = DROP;
            drop_cnt_d = sat_inc16(drop_cnt_q);
          end else if (i_erxd == PRE_NIB) begin
            state_d = PRE;
            err_d   = 1'b0;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!i_erx_dv) begin
          state_d = IDLE;
        end else begin
          if (i_erx_er) err_d = 1'b1;
          if (i_erxd == SFD_NIB) begin
            state_d    = DATA;
            byte_idx_d = '0;
            nib_ph_d   = 1'b0;
            ovf_d      = 1'b0;
            crc_init_c = 1'b1;
`ifdef RX_ADDR_FILTER_EN
            ucast_miss_d = 1'b0;
            bcast_miss_d = 1'b0;
`endif
          end else if (i_erxd != PRE_NIB) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (!i_erx_dv) begin
          state_d = IDLE;
          if (frame_ok_c) begin
            rx_done_d = 1'b1;
            rx_len_d  = LEN_W'(byte_idx_q - IDX_W'(4));
          end else begin
            err_cnt_d = sat_inc16(err_cnt_q);
          end
        end
`ifdef RX_ADDR_FILTER_EN
        else if (da_reject_c) begin
          state_d = DROP;
        end
`endif
        else begin
          if (i_erx_er) err_d = 1'b1;
          if (!nib_ph_q) begin
            nib_lo_d = i_erxd;
            nib_ph_d = 1'b1;
          end else begin
            nib_ph_d = 1'b0;
            crc_en_c = 1'b1;
            if (byte_idx_q < IDX_W'(MAX_LEN)) begin
              buf_we_d    = 1'b1;
              buf_addr_d  = byte_idx_q[IDX_W-1:3];
              buf_be_d    = 8'(1) << byte_idx_q[2:0];
              buf_wdata_d = {8{byte_c}};
              byte_idx_d  = byte_idx_q + IDX_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
`ifdef RX_ADDR_FILTER_EN
            if (byte_idx_q < IDX_W'(6)) begin
              if (byte_c != da_exp_c) ucast_miss_d = 1'b1;
              if (byte_c != 8'hFF)    bcast_miss_d = 1'b1;
            end
`endif
          end
        end
      end
      DROP: begin
        if (!i_erx_dv) state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_mii or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      nib_lo_q    <= 4'h0;
      nib_ph_q    <= 1'b0;
      byte_idx_q  <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= 64'h0;
      buf_be_q    <= 8'h00;
      rx_done_q   <= 1'b0;
      rx_len_q    <= '0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= 16'h0;
      err_cnt_q   <= 16'h0;
    end else begin
      state_q     <= state_d;
      nib_lo_q    <= nib_lo_d;
      nib_ph_q    <= nib_ph_d;
      byte_idx_q  <= byte_idx_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      buf_be_q    <= buf_be_d;
      rx_done_q   <= rx_done_d;
      rx_len_q    <= rx_len_d;
      busy_q      <= busy_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign buf_be      = buf_be_q;
  assign rx_done     = rx_done_q;
  assign rx_len      = rx_len_q;
  assign rx_busy     = busy_q;
  assign rx_drop_cnt = drop_cnt_q;
  assign rx_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Self-checking bench for mii_rx_deframer: directed vector table, multi-cycle
// corner sequences and randomized frames against a frame-level reference model.
module tb_mii_rx_deframer;

  localparam int MAX_LEN = 1536;
  localparam int MIN_LEN = 64;

  logic        clk_mii = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  i_erxd = 4'h0;
  logic        i_erx_dv = 1'b0;
  logic        i_erx_er = 1'b0;
  logic        rx_ack = 1'b0;
  logic        buf_we;
  logic [7:0]  buf_addr;
  logic [63:0] buf_wdata;
  logic [7:0]  buf_be;
  logic        rx_done;
  logic [10:0] rx_len;
  logic        rx_busy;
  logic [15:0] rx_drop_cnt;
  logic [15:0] rx_err_cnt;
`ifdef RX_ADDR_FILTER_EN
  logic [47:0] mac_addr = 48'h0;
  logic        promisc = 1'b1;
`endif

  mii_rx_deframer dut (
    .clk_mii     (clk_mii),
    .rstn        (rstn),
    .i_erxd      (i_erxd),
    .i_erx_dv    (i_erx_dv),
    .i_erx_er    (i_erx_er),
    .rx_ack      (rx_ack),
`ifdef RX_ADDR_FILTER_EN
    .mac_addr    (mac_addr),
    .promisc     (promisc),
`endif
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_wdata   (buf_wdata),
    .buf_be      (buf_be),
    .rx_done     (rx_done),
    .rx_len      (rx_len),
    .rx_busy     (rx_busy),
    .rx_drop_cnt (rx_drop_cnt),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 clk_mii = ~clk_mii;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  be;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit corrupt;
    bit er;
    bit odd;
    bit ack;
    bit exp_done;
    int exp_len;
    int exp_err;
    int exp_drop;
    int exp_writes;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] frame[$];
  int         total = 0;
  int         bad = 0;

  // Capture buffer writes away from the active edge.
  always @(negedge clk_mii) begin
    if (buf_we) wq.push_back({buf_addr, buf_be, buf_wdata});
  end

  // Run-time guard.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input logic [7:0] b[$]);
    logic [31:0] got;
    int n;
    n = b.size();
    got = {b[n-1], b[n-2], b[n-3], b[n-4]};
    return fcs_of(b, n - 4) == got;
  endfunction

  task automatic build_frame(input int len, input bit corrupt, input bit use_da, input logic [47:0] da);
    logic [31:0] fcs;
    frame.delete();
    for (int i = 0; i < len - 4; i++) frame.push_back(8'($urandom));
    if (use_da) for (int i = 0; i < 6; i++) frame[i] = da[8*(5-i) +: 8];
    fcs = fcs_of(frame, len - 4);
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    if (corrupt) frame[4][3] = ~frame[4][3];
  endtask

  task automatic nib(input logic [3:0] n, input logic e);
    @(negedge clk_mii);
    i_erx_dv = 1'b1;
    i_erxd   = n;
    i_erx_er = e;
  endtask

  task automatic send_frame(input bit er, input bit odd);
    wq.delete();
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < frame.size(); i++) begin
      nib(frame[i][3:0], er && (i == 10));
      nib(frame[i][7:4], 1'b0);
    end
    if (odd) nib(4'hA, 1'b0);
    @(negedge clk_mii);
    i_erx_dv = 1'b0;
    i_erx_er = 1'b0;
    i_erxd   = 4'h0;
    repeat (4) @(negedge clk_mii);
  endtask

  task automatic do_ack();
    @(negedge clk_mii);
    rx_ack = 1'b1;
    @(negedge clk_mii);
    rx_ack = 1'b0;
    @(negedge clk_mii);
    chk("ack_clears_done", rx_done, 0);
  endtask

  task automatic check_frame(input string pfx, input int exp_w, input bit exp_done,
                             input int exp_len, input int exp_err, input int exp_drop);
    int mis;
    mis = 0;
    chk({pfx, "_writes"}, wq.size(), exp_w);
    if (exp_w > 0) begin
      for (int i = 0; i < wq.size() && i < frame.size(); i++) begin
        if (wq[i].addr !== 8'(i >> 3) || wq[i].be !== 8'(1 << (i % 8)) || wq[i].data !== {8{frame[i]}})
          mis++;
      end
      chk({pfx, "_content"}, mis, 0);
    end
    chk({pfx, "_done"}, rx_done, exp_done);
    chk({pfx, "_len"}, rx_len, exp_len);
    chk({pfx, "_err_cnt"}, rx_err_cnt, exp_err);
    chk({pfx, "_drop_cnt"}, rx_drop_cnt, exp_drop);
    chk({pfx, "_busy"}, rx_busy, 0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_we"}, buf_we, 0);
    chk({pfx, "_addr"}, buf_addr, 0);
    chk({pfx, "_wdata"}, buf_wdata, 0);
    chk({pfx, "_be"}, buf_be, 0);
    chk({pfx, "_done"}, rx_done, 0);
    chk({pfx, "_len"}, rx_len, 0);
    chk({pfx, "_busy"}, rx_busy, 0);
    chk({pfx, "_drop"}, rx_drop_cnt, 0);
    chk({pfx, "_err"}, rx_err_cnt, 0);
  endtask

  vec_t vecs[12];
  int   m_err, m_drop, m_len, exp_w, len;
  bit   m_done, c, e, o, a, good;

  initial begin
    vecs[0]  = '{64,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,    1, 0, 64};
    vecs[1]  = '{64,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 60,   1, 0, 64};
    vecs[2]  = '{64,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 60,   1, 1, 0};
    vecs[3]  = '{100,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 96,   1, 1, 100};
    vecs[4]  = '{1600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 96,   2, 1, 1536};
    vecs[5]  = '{40,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 96,   3, 1, 40};
    vecs[6]  = '{64,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 96,   4, 1, 64};
    vecs[7]  = '{64,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 96,   5, 1, 64};
    vecs[8]  = '{1536, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1532, 5, 1, 1536};
    vecs[9]  = '{63,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1532, 6, 1, 63};
    vecs[10] = '{1537, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1532, 7, 1, 1536};
    vecs[11] = '{65,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 61,   7, 1, 65};

    // Reset state.
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk_mii);
    check_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk_mii);
    check_zero("post_reset");

    // Directed vector table.
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].ack) do_ack();
      build_frame(vecs[v].len, vecs[v].corrupt, 1'b0, 48'h0);
      send_frame(vecs[v].er, vecs[v].odd);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_done,
                  vecs[v].exp_len, vecs[v].exp_err, vecs[v].exp_drop);
    end

    // Async reset in the middle of a frame.
    build_frame(64, 1'b0, 1'b0, 48'h0);
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nib(frame[i][3:0], 1'b0);
      nib(frame[i][7:4], 1'b0);
    end
    @(negedge clk_mii);
    chk("midreset_busy", rx_busy, 1);
    rstn = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk_mii);
    i_erx_dv = 1'b0;
    i_erxd   = 4'h0;
    @(negedge clk_mii);
    rstn = 1'b1;
    repeat (3) @(negedge clk_mii);
    check_zero("after_midreset");

    // Randomized frames against the frame-level model.
    m_done = 1'b0; m_len = 0; m_err = 0; m_drop = 0;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(20, 140);
      c   = ($urandom_range(0, 4) == 0);
      e   = ($urandom_range(0, 7) == 0);
      o   = ($urandom_range(0, 7) == 0);
      a   = ($urandom_range(0, 1) == 0);
      if (a) begin
        do_ack();
        m_done = 1'b0;
      end
      build_frame(len, c, 1'b0, 48'h0);
      send_frame(e, o);
      if (m_done) begin
        m_drop++;
        exp_w = 0;
      end else begin
        exp_w = (len > MAX_LEN) ? MAX_LEN : len;
        good  = !e && !o && len >= MIN_LEN && len <= MAX_LEN && fcs_ok(frame);
        if (good) begin
          m_done = 1'b1;
          m_len  = len - 4;
        end else begin
          m_err++;
        end
      end
      check_frame($sformatf("rnd%0d", n), exp_w, m_done, m_len, m_err, m_drop);
    end

`ifdef RX_ADDR_FILTER_EN
    // Destination address filter.
    mac_addr = 48'h020000000001;
    promisc  = 1'b0;
    do_ack();
    build_frame(64, 1'b0, 1'b1, 48'h020000000001);
    send_frame(1'b0, 1'b0);
    check_frame("da_match", 64, 1'b1, 60, m_err, m_drop);
    do_ack();
    build_frame(70, 1'b0, 1'b1, 48'hFFFFFFFFFFFF);
    send_frame(1'b0, 1'b0);
    check_frame("da_bcast", 70, 1'b1, 66, m_err, m_drop);
    do_ack();
    build_frame(64, 1'b0, 1'b1, 48'h020000000002);
    send_frame(1'b0, 1'b0);
    check_frame("da_other", 6, 1'b0, 66, m_err, m_drop);
    promisc = 1'b1;
    build_frame(68, 1'b0, 1'b1, 48'h020000000002);
    send_frame(1'b0, 1'b0);
    check_frame("da_promisc", 68, 1'b1, 64, m_err, m_drop);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
